// File: rtl/instr_encoder_if.sv
// Request/write-port bundle for instr_encoder: ALU-op requests in, encoded words out.
// err_cnt is present only when ENC_ERR_CNT_EN is defined.
interface instr_encoder_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic          req_imm;
  logic [3:0]    req_alu;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [11:0]   req_imm12;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          err;
  logic [LW-1:0] level;
`ifdef ENC_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  modport master (
    output flush, req_valid, req_imm, req_alu, req_rd, req_rs1, req_rs2, req_imm12, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, err, level
`ifdef ENC_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  flush, req_valid, req_imm, req_alu, req_rd, req_rs1, req_rs2, req_imm12, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, err, level
`ifdef ENC_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs ALU-op requests into RV32 R/I-type words, buffers them in a FIFO and streams them
// to an instruction-memory write port. Optional saturating error counter: ENC_ERR_CNT_EN.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [AW-1:0] addr_q;
  logic          err_q;

  logic          full;
  logic          empty;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          enc_ok;
  logic          is_shift;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic [11:0]   imm_field;
  logic [31:0]   enc_word;

  always_comb begin
    f3       = 3'd0;
    f7       = 7'd0;
    enc_ok   = 1'b1;
    is_shift = 1'b0;
    case (bus.req_alu)
      4'b0000: f3 = 3'd7;
      4'b0001: f3 = 3'd6;
      4'b0010: f3 = 3'd0;
      4'b0100: begin
        f7     = 7'b0100000;
        enc_ok = !bus.req_imm;
      end
      4'b0011: begin
        f3       = 3'd1;
        is_shift = 1'b1;
      end
      4'b0101: begin
        f3       = 3'd5;
        is_shift = 1'b1;
      end
      4'b0111: f3 = 3'd4;
      default: enc_ok = 1'b0;
    endcase
    // Shift immediates carry only the shamt; the upper immediate bits must be zero.
    imm_field = is_shift ? {7'd0, bus.req_imm12[4:0]} : bus.req_imm12;
    enc_word  = bus.req_imm ? {imm_field, bus.req_rs1, f3, bus.req_rd, OP_I}
                            : {f7, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, OP_R};
  end

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign req_fire = bus.req_valid && !full;
  assign push     = req_fire && enc_ok;
  assign pop      = !empty && bus.wr_ready;

  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        addr_q <= addr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      err_q <= req_fire && !enc_ok;
    end
  end

`ifdef ENC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        err_cnt_q <= 8'd0;
    else if (bus.flush)                                err_cnt_q <= 8'd0;
    else if (req_fire && !enc_ok && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.req_ready = !full;
  assign bus.wr_valid  = !empty;
  assign bus.wr_addr   = addr_q;
  // Storage is not reset, so the head word is masked to zero while the FIFO is empty.
  assign bus.wr_data   = empty ? 32'd0 : mem[rd_ptr];
  assign bus.err       = err_q;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4, AW=2 so address wrap is reachable).
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] exp_words [4];

  instr_encoder_if #(.DEPTH(4), .AW(2)) bus ();
  instr_encoder #(.DEPTH(4), .AW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic imm, input logic [3:0] alu, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm12);
    bus.req_valid = 1'b1;
    bus.req_imm   = imm;
    bus.req_alu   = alu;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm12 = imm12;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.flush = 0; bus.req_valid = 0; bus.req_imm = 0; bus.req_alu = 0;
    bus.req_rd = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_imm12 = 0; bus.wr_ready = 0;
    #12;
    check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    tick();

    // single encodings, each popped in turn
    send(1'b0, 4'b0010, 5'd3, 5'd1, 5'd2, 12'h000);
    check("add_valid", 32'(bus.wr_valid), 32'd1);
    check("add_data", bus.wr_data, 32'h002081B3);
    check("add_addr", 32'(bus.wr_addr), 32'd0);
    check("add_level", 32'(bus.level), 32'd1);
    bus.wr_ready = 1'b1; tick(); bus.wr_ready = 1'b0;
    check("pop_level", 32'(bus.level), 32'd0);
    check("pop_addr", 32'(bus.wr_addr), 32'd1);
    check("pop_data_zero", bus.wr_data, 32'd0);

    send(1'b0, 4'b0100, 5'd5, 5'd6, 5'd7, 12'h000);
    check("sub_data", bus.wr_data, 32'h407302B3);
    check("sub_addr", 32'(bus.wr_addr), 32'd1);
    bus.wr_ready = 1'b1; tick(); bus.wr_ready = 1'b0;

    send(1'b1, 4'b0010, 5'd1, 5'd0, 5'd0, 12'hFFF);
    check("addi_data", bus.wr_data, 32'hFFF00093);
    check("addi_addr", 32'(bus.wr_addr), 32'd2);
    bus.wr_ready = 1'b1; tick(); bus.wr_ready = 1'b0;

    send(1'b1, 4'b0011, 5'd2, 5'd2, 5'd0, 12'hFE3);
    check("slli_data", bus.wr_data, 32'h00311113);
    check("slli_addr", 32'(bus.wr_addr), 32'd3);
    bus.wr_ready = 1'b1; tick(); bus.wr_ready = 1'b0;
    check("addr_wrap", 32'(bus.wr_addr), 32'd0);

    // unencodable requests
    send(1'b0, 4'b1000, 5'd1, 5'd1, 5'd1, 12'h000);
    check("err_1000", 32'(bus.err), 32'd1);
    check("err_1000_level", 32'(bus.level), 32'd0);
    check("err_1000_addr", 32'(bus.wr_addr), 32'd0);
    tick();
    check("err_pulse_end", 32'(bus.err), 32'd0);
    send(1'b1, 4'b0100, 5'd1, 5'd1, 5'd1, 12'h001);
    check("err_isub", 32'(bus.err), 32'd1);
    check("err_isub_level", 32'(bus.level), 32'd0);
    check("err_isub_valid", 32'(bus.wr_valid), 32'd0);
`ifdef ENC_ERR_CNT_EN
    check("err_cnt", 32'(bus.err_cnt), 32'd2);
`endif

    // fill to DEPTH with wr_ready low, then drain in order
    exp_words[0] = 32'h003170B3;
    exp_words[1] = 32'h0062E233;
    exp_words[2] = 32'h0F044393;
    exp_words[3] = 32'h00755493;
    send(1'b0, 4'b0000, 5'd1, 5'd2, 5'd3, 12'h000);
    send(1'b0, 4'b0001, 5'd4, 5'd5, 5'd6, 12'h000);
    send(1'b1, 4'b0111, 5'd7, 5'd8, 5'd0, 12'h0F0);
    send(1'b1, 4'b0101, 5'd9, 5'd10, 5'd0, 12'hFC7);
    check("full_level", 32'(bus.level), 32'd4);
    check("full_ready", 32'(bus.req_ready), 32'd0);
    send(1'b0, 4'b0010, 5'd1, 5'd1, 5'd1, 12'h000);
    check("full_no_push", 32'(bus.level), 32'd4);
    check("full_no_err", 32'(bus.err), 32'd0);
    check("stall_data", bus.wr_data, exp_words[0]);
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_data%0d", i), bus.wr_data, exp_words[i]);
      check($sformatf("drain_addr%0d", i), 32'(bus.wr_addr), 32'(i));
      tick();
    end
    bus.wr_ready = 1'b0;
    check("drain_level", 32'(bus.level), 32'd0);
    check("drain_addr_wrap", 32'(bus.wr_addr), 32'd0);

    // simultaneous push and pop at level 1
    send(1'b0, 4'b0010, 5'd3, 5'd1, 5'd2, 12'h000);
    bus.wr_ready = 1'b1;
    send(1'b0, 4'b0100, 5'd5, 5'd6, 5'd7, 12'h000);
    bus.wr_ready = 1'b0;
    check("pp_level", 32'(bus.level), 32'd1);
    check("pp_data", bus.wr_data, 32'h407302B3);
    check("pp_addr", 32'(bus.wr_addr), 32'd1);

    // flush beats a concurrent push
    send(1'b0, 4'b0010, 5'd3, 5'd1, 5'd2, 12'h000);
    bus.flush = 1'b1;
    send(1'b0, 4'b0010, 5'd3, 5'd1, 5'd2, 12'h000);
    bus.flush = 1'b0;
    check("flush_level", 32'(bus.level), 32'd0);
    check("flush_addr", 32'(bus.wr_addr), 32'd0);
    check("flush_valid", 32'(bus.wr_valid), 32'd0);
`ifdef ENC_ERR_CNT_EN
    check("flush_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif

    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) send(1'b0, 4'b0010, 5'd3, 5'd1, 5'd2, 12'h000);
    bus.wr_ready = 1'b1; tick(); bus.wr_ready = 1'b0;
    check("pre_rst_level", 32'(bus.level), 32'd3);
    check("pre_rst_addr", 32'(bus.wr_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.wr_valid), 32'd0);
    check("arst_level", 32'(bus.level), 32'd0);
    check("arst_addr", 32'(bus.wr_addr), 32'd0);
    check("arst_data", bus.wr_data, 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
